// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch handshake, hazard/write-back inputs and the ID/EX bundle.
// The decode side uses the slave modport; the fetch/pipeline side uses master.
interface id_stage_if #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
);
  logic [DATA_W-1:0] inst;
  logic [DATA_W-1:0] pc_calc;
  logic              stall;
  logic [DATA_W-1:0] pcj_mux;
  logic              choice_mux;

  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [RA_W-1:0]   ex_rd;
  logic              mem_reg_write;
  logic [RA_W-1:0]   mem_rd;

  logic              wb_we;
  logic [RA_W-1:0]   wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              idex_valid;
  logic              idex_reg_write;
  logic              idex_mem_read;
  logic              idex_mem_write;
  logic              idex_alu_src;
  logic [2:0]        idex_alu_op;
  logic [DATA_W-1:0] idex_rs_val;
  logic [DATA_W-1:0] idex_rt_val;
  logic [DATA_W-1:0] idex_imm;
  logic [RA_W-1:0]   idex_rs;
  logic [RA_W-1:0]   idex_rt;
  logic [RA_W-1:0]   idex_rd;

  modport slave (
    input  inst, pc_calc, ex_mem_read, ex_reg_write, ex_rd, mem_reg_write, mem_rd,
           wb_we, wb_addr, wb_data,
    output stall, pcj_mux, choice_mux,
           idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_src,
           idex_alu_op, idex_rs_val, idex_rt_val, idex_imm, idex_rs, idex_rt, idex_rd
  );

  modport master (
    output inst, pc_calc, ex_mem_read, ex_reg_write, ex_rd, mem_reg_write, mem_rd,
           wb_we, wb_addr, wb_data,
    input  stall, pcj_mux, choice_mux,
           idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_src,
           idex_alu_op, idex_rs_val, idex_rt_val, idex_imm, idex_rs, idex_rt, idex_rd
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, 8x16 register file with write-before-read bypass,
// decoder, load-use/branch hazard detection, branch/jump resolution and ID/EX latch.
module id_stage #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input logic      clock,
  input logic      reset,
  id_stage_if.slave bus
);
  localparam int NREG = 1 << RA_W;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;

  // Handshake: idex_valid qualifies the whole idex_* bundle for one cycle (no ready,
  // EX always accepts); stall is the only backpressure and freezes fetch plus IF/ID.
  logic              ifid_valid;
  logic [DATA_W-1:0] ifid_inst;
  logic [DATA_W-1:0] ifid_pc;

  logic [DATA_W-1:0] rf [NREG];

  logic [3:0]        op;
  logic [RA_W-1:0]   rs, rt, rd_field;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rs_val, rt_val;

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_br, uses_rt;
  logic load_use, rs_br_haz, rt_br_haz, branch_haz, taken;
  logic stall_c, choice_c;
  logic [DATA_W-1:0] target;
  logic [RA_W-1:0]   dest;

  assign op       = ifid_inst[15:12];
  assign rs       = ifid_inst[11:9];
  assign rt       = ifid_inst[8:6];
  assign rd_field = ifid_inst[5:3];
  assign imm      = {{(DATA_W-6){ifid_inst[5]}}, ifid_inst[5:0]};

  assign is_r    = (op == OP_R);
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_br   = is_beq | is_bne;
  assign uses_rt = is_r | is_sw | is_br;

  // r0 is hard-wired to zero; otherwise a same-cycle write-back wins over the array.
  assign rs_val = (rs == '0) ? '0 :
                  (bus.wb_we && (bus.wb_addr == rs)) ? bus.wb_data : rf[rs];
  assign rt_val = (rt == '0) ? '0 :
                  (bus.wb_we && (bus.wb_addr == rt)) ? bus.wb_data : rf[rt];

  assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                    ((bus.ex_rd == rs) || (uses_rt && (bus.ex_rd == rt)));

  // Branches compare in ID, so any producer still in EX or MEM must drain first.
  assign rs_br_haz = (rs != '0) &&
                     ((bus.ex_reg_write && (bus.ex_rd == rs)) ||
                      (bus.mem_reg_write && (bus.mem_rd == rs)));
  assign rt_br_haz = (rt != '0) &&
                     ((bus.ex_reg_write && (bus.ex_rd == rt)) ||
                      (bus.mem_reg_write && (bus.mem_rd == rt)));
  assign branch_haz = is_br && (rs_br_haz || rt_br_haz);

  assign stall_c  = ifid_valid && (load_use || branch_haz);
  assign taken    = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
  assign choice_c = ifid_valid && !stall_c && (taken || is_j);
  assign target   = is_j ? {ifid_pc[DATA_W-1:12], ifid_inst[11:0]} : (ifid_pc + imm);

  assign bus.stall      = stall_c;
  assign bus.choice_mux = choice_c;
  assign bus.pcj_mux    = choice_c ? target : '0;

  assign dest = is_r ? rd_field : ((is_addi || is_lw) ? rt : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_inst  <= '0;
      ifid_pc    <= '0;
    end else if (stall_c) begin
      ifid_valid <= ifid_valid;
    end else if (choice_c) begin
      ifid_valid <= 1'b0;
      ifid_inst  <= bus.inst;
      ifid_pc    <= bus.pc_calc;
    end else begin
      ifid_valid <= 1'b1;
      ifid_inst  <= bus.inst;
      ifid_pc    <= bus.pc_calc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (bus.wb_we && (bus.wb_addr != '0)) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.idex_valid     <= 1'b0;
      bus.idex_reg_write <= 1'b0;
      bus.idex_mem_read  <= 1'b0;
      bus.idex_mem_write <= 1'b0;
      bus.idex_alu_src   <= 1'b0;
      bus.idex_alu_op    <= '0;
      bus.idex_rs_val    <= '0;
      bus.idex_rt_val    <= '0;
      bus.idex_imm       <= '0;
      bus.idex_rs        <= '0;
      bus.idex_rt        <= '0;
      bus.idex_rd        <= '0;
    end else if (stall_c || !ifid_valid) begin
      bus.idex_valid     <= 1'b0;
      bus.idex_reg_write <= 1'b0;
      bus.idex_mem_read  <= 1'b0;
      bus.idex_mem_write <= 1'b0;
      bus.idex_alu_src   <= 1'b0;
      bus.idex_alu_op    <= '0;
      bus.idex_rs_val    <= '0;
      bus.idex_rt_val    <= '0;
      bus.idex_imm       <= '0;
      bus.idex_rs        <= '0;
      bus.idex_rt        <= '0;
      bus.idex_rd        <= '0;
    end else begin
      bus.idex_valid     <= 1'b1;
      bus.idex_reg_write <= is_r | is_addi | is_lw;
      bus.idex_mem_read  <= is_lw;
      bus.idex_mem_write <= is_sw;
      bus.idex_alu_src   <= is_addi | is_lw | is_sw;
      bus.idex_alu_op    <= is_r ? ifid_inst[2:0] : 3'b000;
      bus.idex_rs_val    <= rs_val;
      bus.idex_rt_val    <= rt_val;
      bus.idex_imm       <= imm;
      bus.idex_rs        <= rs;
      bus.idex_rt        <= rt;
      bus.idex_rd        <= dest;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX bundles are queued at issue and a
// negedge monitor pops and compares them; fetch-side outputs are checked inline.
module tb_id_stage;
  localparam int W = 64;
  localparam logic [15:0] NOP = 16'h7000;
  localparam logic [W-1:0] ZB = '0;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] idex_act;

  id_stage_if #(.DATA_W(16), .RA_W(3)) bus ();
  id_stage #(.DATA_W(16), .RA_W(3)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  assign idex_act = {bus.idex_reg_write, bus.idex_mem_read, bus.idex_mem_write, bus.idex_alu_src,
                     bus.idex_alu_op, bus.idex_rs_val, bus.idex_rt_val, bus.idex_imm,
                     bus.idex_rs, bus.idex_rt, bus.idex_rd};

  // ctl = {reg_write, mem_read, mem_write, alu_src}
  function automatic logic [W-1:0] pk(input logic [3:0] ctl, input logic [2:0] aop,
                                      input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] im, input logic [2:0] s,
                                      input logic [2:0] t, input logic [2:0] d);
    return {ctl, aop, a, b, im, s, t, d};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [15:0] i, input logic [15:0] p, input bit push,
                     input logic [W-1:0] e);
    bus.inst    = i;
    bus.pc_calc = p;
    if (push) exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_idex"}, idex_act, ZB);
    chk({name, "_valid"}, W'(bus.idex_valid), W'(1'b0));
    chk({name, "_stall"}, W'(bus.stall), W'(1'b0));
    chk({name, "_choice"}, W'(bus.choice_mux), W'(1'b0));
    chk({name, "_pcj"}, W'(bus.pcj_mux), W'(16'h0000));
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && bus.idex_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL idex_unexpected: got %h expected no output", idex_act);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("idex_fields", idex_act, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.inst = NOP; bus.pc_calc = '0;
    bus.ex_mem_read = 0; bus.ex_reg_write = 0; bus.ex_rd = '0;
    bus.mem_reg_write = 0; bus.mem_rd = '0;
    bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk_quiet("reset_init");
    reset = 1'b0;

    // preload r1=5, r2=7, r6=0x1234
    bus.wb_we = 1; bus.wb_addr = 3'd1; bus.wb_data = 16'h0005; cyc(NOP, 16'h0001, 1, ZB);
    bus.wb_addr = 3'd2; bus.wb_data = 16'h0007; cyc(NOP, 16'h0002, 1, ZB);
    bus.wb_addr = 3'd6; bus.wb_data = 16'h1234; cyc(NOP, 16'h0003, 1, ZB);
    bus.wb_we = 0;

    // ADDI r4,r3,-2; r3 is written back while ADDI sits in IF/ID
    cyc(16'h173E, 16'h0004, 1, pk(4'b1001, 3'b000, 16'h00AA, 16'h0000, 16'hFFFE, 3'd3, 3'd4, 3'd4));
    bus.wb_we = 1; bus.wb_addr = 3'd3; bus.wb_data = 16'h00AA;
    cyc(NOP, 16'h0005, 1, ZB);
    bus.wb_we = 0;
    chk("addi_latency_valid", W'(bus.idex_valid), W'(1'b1));
    chk("addi_rd", W'(bus.idex_rd), W'(3'd4));

    // load-use: ADD r5,r2,r1 (funct 1) behind LW r2
    cyc(16'h0469, 16'h0006, 1, pk(4'b1000, 3'b001, 16'h0007, 16'h0005, 16'hFFE9, 3'd2, 3'd1, 3'd5));
    bus.ex_mem_read = 1; bus.ex_rd = 3'd2;
    #1;
    chk("loaduse_stall", W'(bus.stall), W'(1'b1));
    chk("loaduse_choice", W'(bus.choice_mux), W'(1'b0));
    cyc(NOP, 16'h0007, 0, ZB);
    bus.ex_mem_read = 0; bus.ex_rd = '0;
    #1;
    chk("loaduse_release", W'(bus.stall), W'(1'b0));
    chk("loaduse_bubble", W'(bus.idex_valid), W'(1'b0));
    cyc(NOP, 16'h0007, 1, ZB);

    // BEQ r1,r1,+3 at 0x0010: taken, wrong-path fetch squashed
    cyc(16'h4243, 16'h0010, 1, pk(4'b0000, 3'b000, 16'h0005, 16'h0005, 16'h0003, 3'd1, 3'd1, 3'd0));
    #1;
    chk("beq_choice", W'(bus.choice_mux), W'(1'b1));
    chk("beq_pcj", W'(bus.pcj_mux), W'(16'h0013));
    chk("beq_stall", W'(bus.stall), W'(1'b0));
    cyc(NOP, 16'h0011, 0, ZB);
    chk("beq_squash_choice", W'(bus.choice_mux), W'(1'b0));
    cyc(NOP, 16'h0013, 1, ZB);
    chk("beq_squash_bubble", W'(bus.idex_valid), W'(1'b0));

    // J 0xFFF at 0xA005
    cyc(16'h6FFF, 16'hA005, 1, pk(4'b0000, 3'b000, 16'h0000, 16'h0000, 16'hFFFF, 3'd7, 3'd7, 3'd0));
    #1;
    chk("j_choice", W'(bus.choice_mux), W'(1'b1));
    chk("j_pcj", W'(bus.pcj_mux), W'(16'hAFFF));
    cyc(NOP, 16'hA006, 0, ZB);

    // BNE r1,r2,-1 at pc 0: target wraps
    cyc(16'h52BF, 16'h0000, 1, pk(4'b0000, 3'b000, 16'h0005, 16'h0007, 16'hFFFF, 3'd1, 3'd2, 3'd0));
    #1;
    chk("bne_wrap_choice", W'(bus.choice_mux), W'(1'b1));
    chk("bne_wrap_pcj", W'(bus.pcj_mux), W'(16'hFFFF));
    cyc(NOP, 16'h0001, 0, ZB);

    // BEQ r1,r2 not taken
    cyc(16'h4283, 16'h0020, 1, pk(4'b0000, 3'b000, 16'h0005, 16'h0007, 16'h0003, 3'd1, 3'd2, 3'd0));
    #1;
    chk("beq_nt_choice", W'(bus.choice_mux), W'(1'b0));
    chk("beq_nt_pcj", W'(bus.pcj_mux), W'(16'h0000));

    // BNE r6,r1,+2 waits for MEM producer of r6, then compares the bypassed value
    cyc(16'h5C42, 16'h0100, 1, pk(4'b0000, 3'b000, 16'h0005, 16'h0005, 16'h0002, 3'd6, 3'd1, 3'd0));
    bus.mem_reg_write = 1; bus.mem_rd = 3'd6;
    #1;
    chk("bne_haz_stall", W'(bus.stall), W'(1'b1));
    chk("bne_haz_choice", W'(bus.choice_mux), W'(1'b0));
    chk("bne_haz_pcj", W'(bus.pcj_mux), W'(16'h0000));
    cyc(NOP, 16'h0101, 0, ZB);
    bus.mem_reg_write = 0; bus.mem_rd = '0;
    bus.wb_we = 1; bus.wb_addr = 3'd6; bus.wb_data = 16'h0005;
    #1;
    chk("bne_res_stall", W'(bus.stall), W'(1'b0));
    chk("bne_res_choice", W'(bus.choice_mux), W'(1'b0));
    cyc(NOP, 16'h0101, 1, ZB);
    bus.wb_we = 0;

    // mid-run reset while a valid ADD sits in ID/EX
    cyc(16'h0469, 16'h0102, 0, ZB);
    @(negedge clock);
    #1;
    cyc(NOP, 16'h0103, 0, ZB);
    reset = 1'b1;
    #1;
    chk_quiet("reset_mid");
    @(posedge clock);
    #1;
    chk_quiet("reset_hold");
    reset = 1'b0;

    // registers were cleared: ADDI r4,r3,-2 now reads r3 = 0
    cyc(16'h173E, 16'h0200, 1, pk(4'b1001, 3'b000, 16'h0000, 16'h0000, 16'hFFFE, 3'd3, 3'd4, 3'd4));
    cyc(NOP, 16'h0201, 1, ZB);
    chk("post_reset_latency", W'(bus.idex_valid), W'(1'b1));
    cyc(NOP, 16'h0202, 1, ZB);
    @(negedge clock);
    #1;
    // the last NOP is still in IF/ID
    chk("queue_drain", W'(exp_q.size()), W'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
